// File: rtl/seq_blinker_pkg.sv
// Shared types and constants for the sequence blinker: FSM state encoding
// and the speed selector values seen on the speed input.
package seq_blinker_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ON,
    OFF,
    FINALE,
    DONE
  } state_t;

  // Speed selector: each step halves the ON/OFF window lengths.
  localparam logic [1:0] SPD_X1 = 2'd0;
  localparam logic [1:0] SPD_X2 = 2'd1;
  localparam logic [1:0] SPD_X4 = 2'd2;
  localparam logic [1:0] SPD_X8 = 2'd3;

endpackage

// File: rtl/seq_blinker_tick_gen.sv
// Timing-tick prescaler for the sequence blinker. Produces a one-cycle tick
// every TICK_CYCLES clocks; clr restarts the count so a window that begins
// with clr released lasts a whole number of ticks.
module tick_gen #(
  parameter int TICK_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  logic [CNT_W-1:0] cnt;

  assign tick = (cnt == CNT_W'(TICK_CYCLES - 1));

  // Free-running modulo-TICK_CYCLES counter, held at zero while cleared.
  always_ff @(posedge clk) begin
    if (reset || clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_blinker.sv
// Sequence blinker for the Simon Says game: plays back `level` steps from the
// pattern memory, lighting one LED per step for an ON window followed by a
// blank OFF window, then pulses done.
// Optional build macro SEQ_BLINKER_FINALE_EN adds an all-LEDs-on finale
// window after the last step.
module seq_blinker
  import seq_blinker_pkg::*;
#(
  parameter  int TICK_CYCLES = 1_000_000,
  parameter  int NUM_LEDS    = 10,
  parameter  int LEVEL_W     = 4,
  parameter  int ON_TICKS    = 25,
  parameter  int OFF_TICKS   = 10,
  localparam int IDX_W       = $clog2(NUM_LEDS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [LEVEL_W-1:0]  level,
  input  logic [1:0]          speed,
  input  logic [IDX_W-1:0]    led_idx,
  output logic [LEVEL_W-1:0]  count,
  output logic                busy,
  output logic                done,
  output logic [NUM_LEDS-1:0] led_out
);

  localparam int MAX_TICKS = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int DUR_W     = $clog2(MAX_TICKS + 1);

  // Window length in ticks for a base length and speed, never below one tick.
  function automatic logic [DUR_W-1:0] win_len(input int base, input logic [1:0] spd);
    int sh;
    int t;
    case (spd)
      SPD_X1:  sh = 0;
      SPD_X2:  sh = 1;
      SPD_X4:  sh = 2;
      SPD_X8:  sh = 3;
      default: sh = 0;
    endcase
    t = base >> sh;
    if (t < 1) t = 1;
    return DUR_W'(t);
  endfunction

  // One-hot LED drive; indices past the LED bank light nothing.
  function automatic logic [NUM_LEDS-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_LEDS-1:0] v;
    v = '0;
    if (int'(idx) < NUM_LEDS) v[idx] = 1'b1;
    return v;
  endfunction

  state_t             state;
  logic [LEVEL_W-1:0] level_l;
  logic [1:0]         speed_l;
  logic [IDX_W-1:0]   idx_l;
  logic [DUR_W-1:0]   dur;
  logic [DUR_W-1:0]   on_len;
  logic [DUR_W-1:0]   off_len;
  logic               tick;
  logic               clr;
  logic               on_last;
  logic               off_last;
  logic               step_last;

  assign on_len    = win_len(ON_TICKS, speed_l);
  assign off_len   = win_len(OFF_TICKS, speed_l);
  assign on_last   = tick && (dur == on_len - DUR_W'(1));
  assign off_last  = tick && (dur == off_len - DUR_W'(1));
  assign step_last = (count == level_l - LEVEL_W'(1));

  // The prescaler only runs inside timed windows. Windows end on a tick, where
  // the prescaler wraps to zero, so back-to-back windows stay tick-aligned.
  assign clr = (state != ON) && (state != OFF) && (state != FINALE);

  tick_gen #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_tick_gen (
    .clk  (clk),
    .reset(reset),
    .clr  (clr),
    .tick (tick)
  );

  // Playback FSM: step sequencing, window timing and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      count   <= '0;
      led_out <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      dur     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          led_out <= '0;
          busy    <= 1'b0;
          dur     <= '0;
          if (start) begin
            busy    <= 1'b1;
            level_l <= level;
            speed_l <= speed;
            if (level != '0) begin
              count <= '0;
              state <= FETCH;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end

        // Memory data for the current count is valid here.
        FETCH: begin
          idx_l   <= led_idx;
          led_out <= onehot(led_idx);
          dur     <= '0;
          state   <= ON;
        end

        ON: begin
          if (on_last) begin
            dur     <= '0;
            led_out <= '0;
            state   <= OFF;
          end else begin
            led_out <= onehot(idx_l);
            if (tick) dur <= dur + DUR_W'(1);
          end
        end

        OFF: begin
          led_out <= '0;
          if (off_last) begin
            dur <= '0;
            if (step_last) begin
`ifdef SEQ_BLINKER_FINALE_EN
              led_out <= '1;
              state   <= FINALE;
`else
              done  <= 1'b1;
              state <= DONE;
`endif
            end else begin
              count <= count + LEVEL_W'(1);
              state <= FETCH;
            end
          end else if (tick) begin
            dur <= dur + DUR_W'(1);
          end
        end

`ifdef SEQ_BLINKER_FINALE_EN
        FINALE: begin
          if (on_last) begin
            dur     <= '0;
            led_out <= '0;
            done    <= 1'b1;
            state   <= DONE;
          end else if (tick) begin
            dur <= dur + DUR_W'(1);
          end
        end
`endif

        DONE: begin
          busy    <= 1'b0;
          led_out <= '0;
          state   <= IDLE;
        end

        default: begin
          led_out <= '0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/seq_blinker.md
Name: seq_blinker

Overview:
Parametrised successor to the single-step blinker for the Simon Says game.
- Plays back a stored sequence of `level` steps. Each step lights one of NUM_LEDS LEDs for an ON window, then blanks for an OFF window.
- The step address is presented on `count` to the pattern memory. The LED index comes back on `led_idx`.
- Sits between the game FSM (start/level/speed in, done out), the pattern memory (count out, led_idx in), the LEDR bank, and the seven-segment step display (`count`).

Parameters:
- TICK_CYCLES, 1_000_000: clk cycles per timing tick (prescaler period).
- NUM_LEDS, 10: LED outputs; one-hot during ON.
- LEVEL_W, 4: width of level and count.
- ON_TICKS, 25: ticks per ON window at speed 0.
- OFF_TICKS, 10: ticks per OFF window at speed 0.
- IDX_W, $clog2(NUM_LEDS): width of led_idx (derived localparam, not user-set).

Ports:
- clk, in, 1: system clock.
- reset, in, 1: synchronous active-high reset.
- start, in, 1: begin playback; sampled only in IDLE.
- level, in, LEVEL_W: number of steps to play; latched on accepted start.
- speed, in, 2: duration shift; latched on accepted start.
- led_idx, in, IDX_W: LED index for the current `count`, from memory.
- count, out, LEVEL_W: current step address (0-based).
- busy, out, 1: high from accepted start until the done cycle inclusive.
- done, out, 1: single-cycle pulse at end of playback.
- led_out, out, NUM_LEDS: LED drive.

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE; count, led_out, busy and done = 0.
  - Prescaler and duration counters = 0.
  - Takes effect mid-playback too: outputs clear on the next edge and no done pulse is issued.
- Prescaler: counts 0..TICK_CYCLES-1. `tick` is asserted when it reaches TICK_CYCLES-1. It is cleared on every state entry into ON or OFF, so each window is exactly an integer number of ticks.
- Window lengths:
  - on_len = max(1, ON_TICKS >> speed_l)
  - off_len = max(1, OFF_TICKS >> speed_l)
  - speed_l is the latched speed; speed 3 is the fastest.
- States:
  - IDLE:
    - led_out = 0, busy = 0.
    - start=1 with level>0: latch level_l, speed_l; count <= 0; go to FETCH.
    - start=1 with level=0: go to DONE directly. No LED lights.
  - FETCH: lasts exactly 1 cycle, which allows a memory with 1-cycle read latency. Latch led_idx into idx_l; go to ON.
  - ON:
    - led_out = one-hot(idx_l).
    - If idx_l >= NUM_LEDS, led_out = 0 but the step is still timed and counted.
    - After on_len ticks, go to OFF.
  - OFF:
    - led_out = 0.
    - After off_len ticks: if count == level_l-1, go to DONE; else count <= count+1 and go to FETCH.
  - DONE:
    - done = 1 and busy = 1 for exactly one cycle, then IDLE.
    - count holds its final value until the next accepted start.
- Duration per step: 1 + (on_len + off_len) * TICK_CYCLES cycles.
- start while busy is ignored. level and speed changes while busy have no effect.
- start held high: retriggers in the cycle after DONE returns to IDLE.
- level = 2^LEVEL_W-1: plays all steps. count never wraps.

Optional Feature:
- Macro: SEQ_BLINKER_FINALE_EN.
- Defined:
  - After the last OFF window, enter FINALE: led_out = all ones for on_len ticks, then DONE.
  - busy stays high throughout FINALE.
  - level=0 goes to DONE with no finale.
- Undefined: no FINALE state; the last OFF goes straight to DONE.

Decomposition:
- Package seq_blinker_pkg holds:
  - the state enum (IDLE, FETCH, ON, OFF, FINALE, DONE);
  - the speed encoding constants SPD_X1=0, SPD_X2=1, SPD_X4=2, SPD_X8=3.
- One sub-module, tick_gen, holds the prescaler: ports clk, reset, clr, tick; parameter TICK_CYCLES.
- The window counters and FSM stay in seq_blinker.

Test Plan:
All scenarios use TICK_CYCLES=4, ON_TICKS=3, OFF_TICKS=2, NUM_LEDS=10, memory returning led_idx = count+2.
1. Basic playback: start=1 for 1 cycle, level=2, speed=0.
   - FETCH cycle, then led_out=10'b0000000100 for 12 cycles, then 0 for 8 cycles.
   - count=1, then led_out=10'b0000001000 for 12 cycles, then 0 for 8 cycles.
   - done pulses once, 43 cycles after start, with count=1.
2. Speed scaling: level=1, speed=1.
   - ON lasts 4 cycles (3>>1=1 tick), OFF lasts 4 cycles.
   - speed=3 gives 4 and 4 cycles (minimum of 1 tick).
3. Zero level: start with level=0.
   - done the next cycle; led_out stays 0; busy high for 1 cycle.
4. Out-of-range index: memory returns 12.
   - led_out=0 throughout the step; count still advances and done still fires.
5. Reset mid-op: assert reset during the second ON window.
   - Next cycle: led_out=0, count=0, busy=0, no done pulse.
   - A subsequent start replays from step 0.
6. Ignored start and finale:
   - start pulsed during OFF has no effect on timing.
   - With SEQ_BLINKER_FINALE_EN: led_out=10'h3FF for 12 cycles before done.
